// File: rtl/rvfi_pkg.sv
// Shared RVFI record layout and serializer state type, also used by the checkers.
// The record is a flat vector with rvfi_order in the least significant bits.
package rvfi_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_HALT} ser_state_e;

  localparam int ORDER_LSB    = 0;
  localparam int ORDER_W      = 8;
  localparam int INSN_LSB     = 8;
  localparam int INSN_W       = 32;
  localparam int REG_W        = 5;
  localparam int RS1_ADDR_LSB = 40;
  localparam int RS2_ADDR_LSB = 45;
  localparam int RD_ADDR_LSB  = 50;
  localparam int TRAP_LSB     = 55;
  localparam int XFIELD_BASE  = 56;

  // XLEN-dependent fields, packed upward from XFIELD_BASE in this order
  typedef enum logic [3:0] {
    XF_PC_RDATA, XF_PC_WDATA, XF_RS1_RDATA, XF_RS2_RDATA, XF_RD_WDATA,
    XF_MEM_ADDR, XF_MEM_RMASK, XF_MEM_WMASK, XF_MEM_RDATA, XF_MEM_WDATA
  } xfield_e;

  function automatic int xfield_width(xfield_e f, int xlen);
    return (f == XF_MEM_RMASK || f == XF_MEM_WMASK) ? xlen / 8 : xlen;
  endfunction

  function automatic int xfield_lsb(xfield_e f, int xlen);
    case (f)
      XF_MEM_RMASK: return XFIELD_BASE + 6 * xlen;
      XF_MEM_WMASK: return XFIELD_BASE + 6 * xlen + xlen / 8;
      XF_MEM_RDATA: return XFIELD_BASE + 6 * xlen + xlen / 4;
      XF_MEM_WDATA: return XFIELD_BASE + 7 * xlen + xlen / 4;
      default:      return XFIELD_BASE + int'(f) * xlen;
    endcase
  endfunction

  function automatic int rec_width(int xlen);
    return XFIELD_BASE + 8 * xlen + xlen / 4;
  endfunction

endpackage

// File: rtl/rvfi_channel_serializer_if.sv
// Multi-channel RVFI input bundle and single-channel RVFI output of the serializer.
interface rvfi_channel_serializer_if
  import rvfi_pkg::*;
#(
  parameter int NRET = 2,
  parameter int XLEN = 32
);
  localparam int RECW = rec_width(XLEN);

  logic                      enable;
  logic                      flush;
  logic [NRET-1:0]           in_valid;
  logic [NRET-1:0][RECW-1:0] in_rec;
  logic                      out_valid;
  logic [RECW-1:0]           out_rec;

  modport master (output enable, flush, in_valid, in_rec, input  out_valid, out_rec);
  modport slave  (input  enable, flush, in_valid, in_rec, output out_valid, out_rec);
endinterface

// File: rtl/rvfi_rec_fifo.sv
// Record FIFO: up to NRET pushes per cycle (lanes marked in push_mask, written in
// ascending lane order), one pop per cycle, count-based occupancy.
module rvfi_rec_fifo #(
  parameter int NRET  = 2,
  parameter int RECW  = 320,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NRET-1:0]           push_mask,
  input  logic [NRET-1:0][RECW-1:0] push_data,
  input  logic                      pop,
  output logic [RECW-1:0]           head,
  output logic [$clog2(DEPTH):0]    cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [RECW-1:0]          mem [DEPTH];
  logic [AW-1:0]            rd_ptr, wr_ptr;
  logic [NRET-1:0][AW-1:0]  slot;
  logic [CW-1:0]            n_push;

  // Each pushing lane lands at wr_ptr plus the number of pushing lanes below it
  always_comb begin
    n_push = '0;
    for (int i = 0; i < NRET; i++) begin
      slot[i] = wr_ptr + n_push[AW-1:0];
      if (push_mask[i]) n_push = n_push + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NRET; i++)
      if (push_mask[i]) mem[slot[i]] <= push_data[i];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_push[AW-1:0];
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + n_push - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/rvfi_channel_serializer.sv
// Serializes NRET RVFI retire channels into one channel for a single-channel checker,
// checking rvfi_order continuity and halting with a sticky flag on any dropped record.
module rvfi_channel_serializer
  import rvfi_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int XLEN  = 32,
  parameter int DEPTH = 4   // power of two, >= NRET
) (
  input  logic                      clk,
  input  logic                      resetn,
  rvfi_channel_serializer_if.slave  bus,
  output logic                      overflow,
  output logic                      order_err,
  output logic                      busy,
  output logic [15:0]               count
);
  localparam int RECW = rec_width(XLEN);
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  ser_state_e                   state;
  logic [CW-1:0]                cnt, free_slots, taken;
  logic [RECW-1:0]              head;
  logic [NRET-1:0]              acc_mask;
  logic [NRET-1:0][ORDER_W-1:0] lane_order;
  logic [ORDER_W-1:0]           last_order, prev_order;
  logic                         seed, seeded;
  logic                         pop, push_en, drop, seq_err, emit;

  for (genvar g = 0; g < NRET; g++) begin : g_lane
    assign lane_order[g] = bus.in_rec[g][ORDER_LSB +: ORDER_W];
  end

  // A pop only frees a slot for this cycle's push when the FIFO is full; otherwise
  // the push sees only the currently free entries.
  always_comb begin
    pop        = ((state == ST_RUN) || (state == ST_DRAIN)) && (cnt != '0);
    push_en    = ((state == ST_IDLE) || (state == ST_RUN)) && bus.enable;
    free_slots = (cnt == DEPTH_C) ? CW'(pop) : DEPTH_C - cnt;
    acc_mask   = '0;
    taken      = '0;
    drop       = 1'b0;
    seq_err    = 1'b0;
    prev_order = last_order;
    seeded     = seed;
    for (int i = 0; i < NRET; i++) begin
      if (push_en && bus.in_valid[i]) begin
        if (taken < free_slots) begin
          acc_mask[i] = 1'b1;
          taken       = taken + CW'(1);
          if (seeded && (lane_order[i] != prev_order + ORDER_W'(1))) seq_err = 1'b1;
          prev_order  = lane_order[i];
          seeded      = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    emit = pop && !drop;
  end

  rvfi_rec_fifo #(.NRET(NRET), .RECW(RECW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push_mask (acc_mask),
    .push_data (bus.in_rec),
    .pop       (pop),
    .head      (head),
    .cnt       (cnt)
  );

  // The entry popped on the overflow edge is discarded; everything after is frozen.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      bus.out_valid <= 1'b0;
      bus.out_rec   <= '0;
      overflow      <= 1'b0;
      order_err     <= 1'b0;
      count         <= '0;
      last_order    <= '0;
      seed          <= 1'b0;
    end else begin
      bus.out_valid <= emit;
      if (emit) begin
        bus.out_rec <= head;
        count       <= (count == 16'hFFFF) ? count : count + 16'd1;
      end
      if (acc_mask != '0) begin
        last_order <= prev_order;
        seed       <= 1'b1;
      end
      if (seq_err) order_err <= 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        state    <= ST_HALT;
      end else begin
        case (state)
          ST_IDLE:  if (bus.enable) state <= ST_RUN;
          ST_RUN:   if (bus.flush)  state <= ST_DRAIN;
          ST_DRAIN: if (cnt == '0)  state <= ST_IDLE;
          default:  state <= ST_HALT;
        endcase
      end
    end
  end

  assign busy = (state != ST_IDLE) || (cnt != '0);

endmodule

// File: tb/tb_rvfi_channel_serializer.sv
// Directed and randomized bench for rvfi_channel_serializer against a queue-based model.
module tb_rvfi_channel_serializer;
  import rvfi_pkg::*;

  localparam int NRET = 2;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int RECW = rec_width(XLEN);
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALT = 3;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic ovf, oerr, busy, ovf2, oerr2, busy2;
  logic [15:0] count, count2;

  rvfi_channel_serializer_if #(.NRET(NRET), .XLEN(XLEN)) bus ();
  rvfi_channel_serializer_if #(.NRET(NRET), .XLEN(XLEN)) bus2 ();

  assign bus2.enable   = bus.enable;
  assign bus2.flush    = bus.flush;
  assign bus2.in_valid = bus.in_valid;
  assign bus2.in_rec   = bus.in_rec;

  rvfi_channel_serializer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .bus(bus.slave),
    .overflow(ovf), .order_err(oerr), .busy(busy), .count(count));

  // Second instance with a two-entry FIFO, where a full FIFO is reachable in RUN
  rvfi_channel_serializer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(2)) dut2 (
    .clk(clk), .resetn(resetn), .bus(bus2.slave),
    .overflow(ovf2), .order_err(oerr2), .busy(busy2), .count(count2));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, stepno = 0;

  int              mmode;
  logic [RECW-1:0] mq[$];
  logic            m_out_valid, m_ovf, m_oerr, m_seed;
  logic [RECW-1:0] m_out_rec;
  logic [7:0]      m_last;
  int              m_count;

  task automatic chk(input string tag, input logic [RECW-1:0] got, input logic [RECW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, stepno, got, exp);
    end
  endtask

  function automatic logic [RECW-1:0] mkrec(input logic [7:0] ord);
    logic [RECW-1:0] r;
    r = '0;
    for (int w = 0; w + 32 <= RECW; w += 32) r[w +: 32] = $urandom;
    r[ORDER_LSB +: ORDER_W] = ord;
    return r;
  endfunction

  task automatic model_reset();
    mmode = M_IDLE; mq.delete();
    m_out_valid = 0; m_out_rec = '0; m_ovf = 0; m_oerr = 0;
    m_seed = 0; m_last = 0; m_count = 0;
  endtask

  task automatic model_edge(input logic en, input logic fl, input logic [NRET-1:0] v,
                            input logic [NRET-1:0][RECW-1:0] recs);
    logic [RECW-1:0] acc[$];
    logic [RECW-1:0] h;
    logic [7:0] o;
    bit drop, pop, was_empty;
    int room;
    drop = 0;
    was_empty = (mq.size() == 0);
    pop = (mmode == M_RUN || mmode == M_DRAIN) && !was_empty;
    if ((mmode == M_IDLE || mmode == M_RUN) && en) begin
      room = (mq.size() == DEPTH) ? int'(pop) : DEPTH - mq.size();
      for (int i = 0; i < NRET; i++)
        if (v[i]) begin
          if (acc.size() < room) acc.push_back(recs[i]);
          else drop = 1;
        end
    end
    foreach (acc[k]) begin
      o = acc[k][7:0];
      if (m_seed && o != m_last + 8'd1) m_oerr = 1;
      m_last = o;
      m_seed = 1;
    end
    m_out_valid = 0;
    if (pop) begin
      h = mq.pop_front();
      if (!drop) begin
        m_out_valid = 1;
        m_out_rec = h;
        if (m_count < 65535) m_count++;
      end
    end
    foreach (acc[k]) mq.push_back(acc[k]);
    if (drop) begin
      m_ovf = 1;
      mmode = M_HALT;
    end else begin
      case (mmode)
        M_IDLE:  if (en) mmode = M_RUN;
        M_RUN:   if (fl) mmode = M_DRAIN;
        M_DRAIN: if (was_empty) mmode = M_IDLE;
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, RECW'(bus.out_valid), RECW'(m_out_valid));
    chk({tag, ".out_rec"},   bus.out_rec, m_out_rec);
    chk({tag, ".overflow"},  RECW'(ovf), RECW'(m_ovf));
    chk({tag, ".order_err"}, RECW'(oerr), RECW'(m_oerr));
    chk({tag, ".busy"},      RECW'(busy), RECW'((mmode != M_IDLE) || (mq.size() != 0)));
    chk({tag, ".count"},     RECW'(count), RECW'(m_count));
  endtask

  task automatic step(input logic en, input logic fl, input logic [1:0] v,
                      input logic [7:0] o0, input logic [7:0] o1);
    bus.enable = en;
    bus.flush = fl;
    bus.in_valid = v;
    bus.in_rec[0] = mkrec(o0);
    bus.in_rec[1] = mkrec(o1);
    model_edge(en, fl, v, bus.in_rec);
    @(posedge clk);
    #1;
    stepno++;
    check_all("step");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 8'd0, 8'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.enable = 0; bus.flush = 0; bus.in_valid = '0; bus.in_rec = '0;
    model_reset();
    #1 check_all("rst_async");
    @(posedge clk);
    #1 check_all("rst_hold");
    resetn = 1'b1;
  endtask

  initial begin
    logic [7:0] nxt, o0, o1;
    logic [1:0] v;
    logic en, fl;

    #2 do_reset();

    // Two channels in one cycle come out on consecutive cycles
    step(1, 0, 2'b11, 8'd0, 8'd1);
    idle(1);
    chk("r030.o0", RECW'(bus.out_rec[7:0]), RECW'(8'd0));
    idle(1);
    chk("r030.o1", RECW'(bus.out_rec[7:0]), RECW'(8'd1));
    idle(1);
    chk("r030.count", RECW'(count), RECW'(16'd2));

    // Order gap flags, 8-bit wrap does not
    do_reset();
    step(1, 0, 2'b01, 8'd7, 8'd0);
    chk("r032.seed", RECW'(oerr), RECW'(1'b0));
    step(1, 0, 2'b01, 8'd9, 8'd0);
    chk("r032.gap", RECW'(oerr), RECW'(1'b1));
    idle(3);
    do_reset();
    step(1, 0, 2'b01, 8'd255, 8'd0);
    step(1, 0, 2'b01, 8'd0, 8'd0);
    step(1, 0, 2'b11, 8'd1, 8'd2);
    chk("r032.wrap", RECW'(oerr), RECW'(1'b0));
    idle(4);

    // Overflow on the third edge, then HALT
    do_reset();
    step(1, 0, 2'b11, 8'd0, 8'd1);
    step(1, 0, 2'b11, 8'd2, 8'd3);
    chk("r031.pre", RECW'(ovf), RECW'(1'b0));
    step(1, 0, 2'b11, 8'd4, 8'd5);
    chk("r031.ovf", RECW'(ovf), RECW'(1'b1));
    step(1, 0, 2'b11, 8'd6, 8'd7);
    idle(3);
    chk("r031.halt_vld", RECW'(bus.out_valid), RECW'(1'b0));

    // Flush drains the three buffered records, then IDLE ignores disabled input
    do_reset();
    step(1, 0, 2'b11, 8'd0, 8'd1);
    step(1, 0, 2'b11, 8'd2, 8'd3);
    step(0, 1, 2'b00, 8'd0, 8'd0);
    idle(3);
    chk("r033.busy", RECW'(busy), RECW'(1'b0));
    step(0, 0, 2'b11, 8'd4, 8'd5);
    idle(2);
    chk("r033.nopush", RECW'(count), RECW'(16'd4));

    // Asynchronous reset with two records buffered
    do_reset();
    step(1, 0, 2'b11, 8'd0, 8'd1);
    step(1, 0, 2'b01, 8'd2, 8'd0);
    #2 do_reset();
    chk("r034.count", RECW'(count), RECW'(16'd0));
    idle(3);
    chk("r034.stale", RECW'(bus.out_valid), RECW'(1'b0));

    // Full FIFO with one valid channel during a pop (two-entry instance)
    do_reset();
    step(1, 0, 2'b11, 8'd0, 8'd1);
    step(1, 0, 2'b01, 8'd2, 8'd0);
    chk("r035.ovf", RECW'(ovf2), RECW'(1'b0));
    chk("r035.o0", RECW'({bus2.out_valid, bus2.out_rec[7:0]}), RECW'(9'h100));
    idle(1);
    chk("r035.o1", RECW'({bus2.out_valid, bus2.out_rec[7:0]}), RECW'(9'h101));
    idle(1);
    chk("r035.o2", RECW'({bus2.out_valid, bus2.out_rec[7:0]}), RECW'(9'h102));
    chk("r035.count", RECW'({ovf2, count2}), RECW'(17'd3));

    // Randomized traffic with occasional flushes and order gaps
    for (int r = 0; r < 8; r++) begin
      do_reset();
      nxt = 8'($urandom);
      for (int s = 0; s < 16; s++) begin
        en = ($urandom_range(0, 3) != 0);
        fl = ($urandom_range(0, 7) == 0);
        v  = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) nxt = nxt + 8'd3;
        o0 = nxt;
        o1 = v[0] ? nxt + 8'd1 : nxt;
        if (en) nxt = nxt + 8'(v[0]) + 8'(v[1]);
        step(en, fl, v, o0, o1);
      end
      idle(6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvfi_channel_serializer.md
RVFI_CHANNEL_SERIALIZER -- requirements
Module: rvfi_channel_serializer

Interface
REQ-001 SHALL have parameter NRET, default 2, number of RVFI retire channels at the input.
REQ-002 SHALL have parameter XLEN, default 32, register and PC width.
REQ-003 SHALL have parameter DEPTH, default 4, FIFO entries; must be a power of two and >= NRET.
REQ-004 SHALL have one clock and asynchronous active-low reset: clk input 1 is the rising-edge clock; resetn input 1 is the asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1 bit, which qualifies the input bundle.
REQ-006 SHALL have port flush, input, 1 bit, a one-cycle pulse requesting a drain and stop.
REQ-007 SHALL have port in_valid, input, NRET bits, rvfi_valid per channel.
REQ-008 SHALL have port in_rec, input, NRET*RECW bits, the packed per-channel record (order, insn, rs1/rs2 addr, rd, pre/post pc, pre rs1/rs2, post_rd, trap, mem addr/rmask/wmask/rdata/wdata).
REQ-009 SHALL have port out_valid, output, 1 bit, single-channel rvfi_valid for a one-channel checker.
REQ-010 SHALL have port out_rec, output, RECW bits, the record being presented.
REQ-011 SHALL have port overflow, output, 1 bit, sticky flag: an input record was dropped.
REQ-012 SHALL have port order_err, output, 1 bit, sticky flag: a non-consecutive rvfi_order was accepted.
REQ-013 SHALL have port busy, output, 1 bit, high when the state is not IDLE or the FIFO is non-empty.
REQ-014 SHALL have port count, output, 16 bits, number of records emitted; saturates at 16'hFFFF.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN and HALT.
- IDLE->RUN on the first cycle with enable=1.
- RUN->DRAIN on flush=1.
- DRAIN->IDLE when the FIFO is empty.
- any state->HALT when overflow sets.
- HALT is left only by reset.
REQ-016 SHALL push in RUN only when enable=1, and SHALL push valid channels in ascending channel index, up to NRET per cycle.
REQ-017 SHALL accept the lowest-index valid channels that fit when the valid channels exceed the free slots, drop the remainder, and set overflow on the next edge.
REQ-018 SHALL pop at most one entry per cycle when not empty in RUN or DRAIN; out_valid and out_rec SHALL be registered.
REQ-019 SHALL have a minimum latency of 1 cycle from acceptance (edge N) to out_valid (cycle after edge N); in-order FIFO semantics.
REQ-020 SHALL use count-based full/empty; a simultaneous push and pop on a full FIFO SHALL count the pop slot as free for that cycle's push.
REQ-021 SHALL wrap pointers modulo DEPTH, with occupancy held in a log2(DEPTH)+1 bit counter.
REQ-022 SHALL hold the last accepted order internally; each accepted record other than the first after reset SHALL have order == last+1 (8-bit wrap: 255->0), otherwise order_err sets; the first accepted record seeds last.
REQ-023 SHALL, in HALT, suppress out_valid and ignore pushes and pops; the FIFO contents are frozen.
REQ-024 SHALL ignore flush in IDLE, DRAIN and HALT; flush and enable in the same RUN cycle SHALL accept that cycle's bundle and then enter DRAIN.
REQ-025 SHALL keep out_rec unchanged when out_valid=0.

Reset
REQ-026 SHALL, on resetn=0 (asynchronous), immediately set state=IDLE, pointers and occupancy to 0, out_valid=0, out_rec=0, overflow=0, order_err=0, count=0, busy=0, and clear the order-seed flag.
REQ-027 SHALL, on reset mid-operation, discard all buffered records; the first edge after deassertion behaves as in IDLE.

Structure
REQ-028 SHALL take RECW, the field offsets and widths of the packed record, and the state enum from the shared package rvfi_pkg, also used by the checkers.
REQ-029 SHALL place the storage, pointers and occupancy in one sub-module rvfi_rec_fifo (multi-push, single-pop).

Verification
REQ-030 The bench SHALL cover: NRET=2, enable=1, both channels valid with orders 0,1 in one cycle -> out_valid on the next 2 cycles with orders 0 then 1; count=2.
REQ-031 The bench SHALL cover: DEPTH=4, three consecutive cycles with both channels valid (orders 0..5) -> overflow=1 on the third edge, state HALT, out_valid=0 thereafter, order 5 dropped.
REQ-032 The bench SHALL cover: accepted orders 7 then 9 -> order_err=1 one edge after acceptance of 9; orders 255 then 0 -> order_err stays 0.
REQ-033 The bench SHALL cover: flush with 3 entries buffered -> 3 more outputs, then busy=0 and state IDLE; later in_valid with enable=0 -> no push.
REQ-034 The bench SHALL cover: resetn low for 1 cycle while 2 entries are buffered -> out_valid=0 asynchronously, count=0, no stale record emitted after release.
REQ-035 The bench SHALL cover: full FIFO with a single valid channel during a pop -> accepted, overflow stays 0.
